// File: rtl/seg7_pkg.sv
// Shared 7-segment code constants and the pattern decoder used by the monitor.
package seg7_pkg;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // legal: pattern is one of the 16 hex codes; blank: all segments dark
    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] digit;
    } seg7_dec_t;

    function automatic seg7_dec_t seg7_decode(input logic [6:0] pat);
        seg7_dec_t r;
        r.legal = 1'b1;
        r.blank = 1'b0;
        r.digit = 4'h0;
        case (pat)
            SEG_0:     r.digit = 4'h0;
            SEG_1:     r.digit = 4'h1;
            SEG_2:     r.digit = 4'h2;
            SEG_3:     r.digit = 4'h3;
            SEG_4:     r.digit = 4'h4;
            SEG_5:     r.digit = 4'h5;
            SEG_6:     r.digit = 4'h6;
            SEG_7:     r.digit = 4'h7;
            SEG_8:     r.digit = 4'h8;
            SEG_9:     r.digit = 4'h9;
            SEG_A:     r.digit = 4'hA;
            SEG_B:     r.digit = 4'hB;
            SEG_C:     r.digit = 4'hC;
            SEG_D:     r.digit = 4'hD;
            SEG_E:     r.digit = 4'hE;
            SEG_F:     r.digit = 4'hF;
            SEG_BLANK: begin
                r.legal = 1'b0;
                r.blank = 1'b1;
            end
            default:   r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Stability qualifier: a pattern counts as stable once it has been sampled on
// STABLE_CYCLES consecutive edges.
module seg7_stable_filter #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg7,
    output logic       stable,
    output logic [6:0] pattern
);
    import seg7_pkg::*;

    localparam int            CW      = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [6:0]    seg_d, seg_q;
    logic [CW-1:0] stab_cnt_d, stab_cnt_q;

    // Count consecutive matching samples; any change restarts qualification
    always_comb begin
        seg_d      = seg7;
        stab_cnt_d = stab_cnt_q;
        if (seg7 != seg_q)
            stab_cnt_d = '0;
        else if (stab_cnt_q != CNT_MAX)
            stab_cnt_d = stab_cnt_q + 1'b1;
    end

    // Sample register resets to blank so a held pattern re-qualifies from scratch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_q      <= SEG_BLANK;
            stab_cnt_q <= '0;
        end else begin
            seg_q      <= seg_d;
            stab_cnt_q <= stab_cnt_d;
        end
    end

    assign stable  = (stab_cnt_q == CNT_MAX);
    assign pattern = seg_q;

endmodule

// File: rtl/seg7_monitor.sv
// 7-segment bus monitor: qualifies, decodes and checks the step sequence of a
// counter display, counting illegal patterns and non-adjacent steps.
module seg7_monitor
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       seg7,
    input  logic             clr_err,
    output logic [3:0]       value,
    output logic             value_vld,
    output logic             new_digit,
    output logic             step_vld,
    output logic             dir,
    output logic             step_err,
    output logic             bad_pat,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic       stable;
    logic [6:0] pattern;

    seg7_stable_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
        .clk     (clk),
        .rst     (rst),
        .seg7    (seg7),
        .stable  (stable),
        .pattern (pattern)
    );

    seg7_dec_t  dec;
    logic       accept;
    logic       err_evt;
    logic [3:0] val_up, val_dn;

    logic [6:0]       last_pat_d, last_pat_q;
    logic [3:0]       value_d, value_q;
    logic             value_vld_d, value_vld_q;
    logic             have_prev_d, have_prev_q;
    logic             dir_d, dir_q;
    logic             new_digit_d, new_digit_q;
    logic             step_vld_d, step_vld_q;
    logic             step_err_d, step_err_q;
    logic             bad_pat_d, bad_pat_q;
    logic [ERR_W-1:0] err_cnt_d, err_cnt_q;

    // Accept each distinct stable pattern once; classify it and infer the step
    always_comb begin
        dec         = seg7_decode(pattern);
        accept      = stable && (pattern != last_pat_q);
        val_up      = value_q + 4'd1;
        val_dn      = value_q - 4'd1;
        last_pat_d  = last_pat_q;
        value_d     = value_q;
        value_vld_d = value_vld_q;
        have_prev_d = have_prev_q;
        dir_d       = dir_q;
        new_digit_d = 1'b0;
        step_vld_d  = 1'b0;
        step_err_d  = 1'b0;
        bad_pat_d   = 1'b0;
        if (accept) begin
            last_pat_d = pattern;
            if (dec.blank) begin
                value_vld_d = 1'b0;
                have_prev_d = 1'b0;
            end else if (dec.legal) begin
                value_d     = dec.digit;
                value_vld_d = 1'b1;
                new_digit_d = 1'b1;
                have_prev_d = 1'b1;
                // value_q doubles as the previous digit: both update together
                if (have_prev_q) begin
                    if (dec.digit == val_up) begin
                        step_vld_d = 1'b1;
                        dir_d      = 1'b1;
                    end else if (dec.digit == val_dn) begin
                        step_vld_d = 1'b1;
                        dir_d      = 1'b0;
                    end else begin
                        step_err_d = 1'b1;
                    end
                end
            end else begin
                bad_pat_d   = 1'b1;
                have_prev_d = 1'b0;
            end
        end
    end

    // Saturating error count; a clear that meets an error event leaves that event counted
    always_comb begin
        err_evt   = step_err_d | bad_pat_d;
        err_cnt_d = err_cnt_q;
        if (clr_err)
            err_cnt_d = err_evt ? ERR_W'(1) : '0;
        else if (err_evt && err_cnt_q != ERR_MAX)
            err_cnt_d = err_cnt_q + 1'b1;
    end

    // Register all monitor state and the one-cycle pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_pat_q  <= SEG_BLANK;
            value_q     <= 4'h0;
            value_vld_q <= 1'b0;
            have_prev_q <= 1'b0;
            dir_q       <= 1'b0;
            new_digit_q <= 1'b0;
            step_vld_q  <= 1'b0;
            step_err_q  <= 1'b0;
            bad_pat_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            last_pat_q  <= last_pat_d;
            value_q     <= value_d;
            value_vld_q <= value_vld_d;
            have_prev_q <= have_prev_d;
            dir_q       <= dir_d;
            new_digit_q <= new_digit_d;
            step_vld_q  <= step_vld_d;
            step_err_q  <= step_err_d;
            bad_pat_q   <= bad_pat_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign value     = value_q;
    assign value_vld = value_vld_q;
    assign new_digit = new_digit_q;
    assign step_vld  = step_vld_q;
    assign dir       = dir_q;
    assign step_err  = step_err_q;
    assign bad_pat   = bad_pat_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_seg7_monitor.sv
// Bench for seg7_monitor: directed table, hand sequences and random traffic
// checked every cycle against a window-based behavioural model.
module tb_seg7_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg7 = 7'h40;
    logic       clr_err = 1'b0;
    logic [3:0] value;
    logic       value_vld, new_digit, step_vld, dir, step_err, bad_pat;
    logic [7:0] err_cnt;

    seg7_monitor #(.STABLE_CYCLES(4), .ERR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg7      (seg7),
        .clr_err   (clr_err),
        .value     (value),
        .value_vld (value_vld),
        .new_digit (new_digit),
        .step_vld  (step_vld),
        .dir       (dir),
        .step_err  (step_err),
        .bad_pat   (bad_pat),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // ---------------- reference model ----------------
    int m_value, m_vld, m_dir, m_hp, m_last, m_err;
    int m_new, m_step, m_serr, m_bad;
    int hist[$];

    // observed DUT pulse counts, cleared per table entry
    int o_new, o_step, o_serr, o_bad;

    function automatic int lookup(input int p);
        for (int i = 0; i < 16; i++)
            if (int'(codes[i]) == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_value = 0; m_vld = 0; m_dir = 0; m_hp = 0; m_last = 'h7F; m_err = 0;
        m_new = 0; m_step = 0; m_serr = 0; m_bad = 0;
        hist.delete();
    endtask

    // One rising edge: decide on the four samples before this edge, then record this one
    task automatic model_edge(input int s, input bit c);
        int p, d, diff;
        bit ev;
        m_new = 0; m_step = 0; m_serr = 0; m_bad = 0;
        if (hist.size() == 4 && hist[0] == hist[1] && hist[1] == hist[2] &&
            hist[2] == hist[3] && hist[3] != m_last) begin
            p = hist[3];
            m_last = p;
            d = lookup(p);
            if (p == 'h7F) begin
                m_vld = 0; m_hp = 0;
            end else if (d < 0) begin
                m_bad = 1; m_hp = 0;
            end else begin
                m_new = 1;
                if (m_hp != 0) begin
                    diff = (d - m_value + 16) % 16;
                    if (diff == 1)       begin m_step = 1; m_dir = 1; end
                    else if (diff == 15) begin m_step = 1; m_dir = 0; end
                    else                 m_serr = 1;
                end
                m_value = d; m_vld = 1; m_hp = 1;
            end
        end
        ev = (m_serr != 0) || (m_bad != 0);
        if (c) m_err = ev ? 1 : 0;
        else if (ev && m_err < 255) m_err++;
        hist.push_back(s);
        if (hist.size() > 4) void'(hist.pop_front());
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        check("value",     int'(value),     m_value);
        check("value_vld", int'(value_vld), m_vld);
        check("dir",       int'(dir),       m_dir);
        check("new_digit", int'(new_digit), m_new);
        check("step_vld",  int'(step_vld),  m_step);
        check("step_err",  int'(step_err),  m_serr);
        check("bad_pat",   int'(bad_pat),   m_bad);
        check("err_cnt",   int'(err_cnt),   m_err);
    endtask

    // Drive one sample, clock it, advance the model and compare 1 time unit later
    task automatic step(input logic [6:0] s, input bit c);
        seg7 = s; clr_err = c;
        @(posedge clk);
        if (!rst) model_reset(); else model_edge(int'(s), c);
        #1;
        compare_all();
        o_new  += int'(new_digit);
        o_step += int'(step_vld);
        o_serr += int'(step_err);
        o_bad  += int'(bad_pat);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [6:0] seg;
        int         hold;
        bit         clr_last;
        int         n_new, n_step, n_serr, n_bad;
        int         val, vld, dr, err;
    } vec_t;

    vec_t vt [15];

    initial begin
        int first_new;
        int nsat;
        logic [6:0] p;
        vt[0]  = '{7'h40,  6, 1'b0, 1, 0, 0, 0, 'h0, 1, 0, 0};
        vt[1]  = '{7'h7F,  6, 1'b0, 0, 0, 0, 0, 'h0, 0, 0, 0};
        vt[2]  = '{7'h79, 10, 1'b0, 1, 0, 0, 0, 'h1, 1, 0, 0};
        vt[3]  = '{7'h24,  6, 1'b0, 1, 1, 0, 0, 'h2, 1, 1, 0};
        vt[4]  = '{7'h30,  6, 1'b0, 1, 1, 0, 0, 'h3, 1, 1, 0};
        vt[5]  = '{7'h0E,  6, 1'b0, 1, 0, 1, 0, 'hF, 1, 1, 1};
        vt[6]  = '{7'h40,  6, 1'b0, 1, 1, 0, 0, 'h0, 1, 1, 1};
        vt[7]  = '{7'h0E,  6, 1'b0, 1, 1, 0, 0, 'hF, 1, 0, 1};
        vt[8]  = '{7'h79,  6, 1'b0, 1, 0, 1, 0, 'h1, 1, 0, 2};
        vt[9]  = '{7'h24,  2, 1'b0, 0, 0, 0, 0, 'h1, 1, 0, 2};
        vt[10] = '{7'h79,  6, 1'b0, 0, 0, 0, 0, 'h1, 1, 0, 2};
        vt[11] = '{7'h30,  6, 1'b0, 1, 0, 1, 0, 'h3, 1, 0, 3};
        vt[12] = '{7'h7E,  6, 1'b0, 0, 0, 0, 1, 'h3, 1, 0, 4};
        vt[13] = '{7'h30,  6, 1'b0, 1, 0, 0, 0, 'h3, 1, 0, 4};
        vt[14] = '{7'h78,  5, 1'b1, 1, 0, 1, 0, 'h7, 1, 0, 1};

        // Reset with a digit on the bus: everything idle, nothing accepted
        model_reset();
        #1 rst = 1'b0;
        #1;
        compare_all();
        step(7'h40, 1'b0);
        step(7'h40, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            o_new = 0; o_step = 0; o_serr = 0; o_bad = 0;
            for (int k = 0; k < vt[i].hold; k++)
                step(vt[i].seg, vt[i].clr_last && (k == vt[i].hold - 1));
            check($sformatf("tbl%0d.n_new", i),  o_new,            vt[i].n_new);
            check($sformatf("tbl%0d.n_step", i), o_step,           vt[i].n_step);
            check($sformatf("tbl%0d.n_serr", i), o_serr,           vt[i].n_serr);
            check($sformatf("tbl%0d.n_bad", i),  o_bad,            vt[i].n_bad);
            check($sformatf("tbl%0d.value", i),  int'(value),      vt[i].val);
            check($sformatf("tbl%0d.vld", i),    int'(value_vld),  vt[i].vld);
            check($sformatf("tbl%0d.dir", i),    int'(dir),        vt[i].dr);
            check($sformatf("tbl%0d.err", i),    int'(err_cnt),    vt[i].err);
        end

        // Alternate 1 and 3 (never adjacent) until the error counter saturates
        for (nsat = 0; nsat < 260; nsat++) begin
            p = nsat[0] ? 7'h30 : 7'h79;
            for (int k = 0; k < 5; k++) step(p, 1'b0);
        end
        check("sat.err", int'(err_cnt), 255);
        step(p, 1'b1);
        check("clr.err", int'(err_cnt), 0);

        // Reset in the middle of qualifying a new pattern
        step(7'h24, 1'b0);
        step(7'h24, 1'b0);
        step(7'h24, 1'b0);
        #3 rst = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("rstmid.value", int'(value), 0);
        check("rstmid.err", int'(err_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
        first_new = -1;
        for (int k = 1; k <= 10; k++) begin
            step(7'h24, 1'b0);
            if (new_digit && first_new < 0) first_new = k;
        end
        check("rstmid.latency", first_new, 5);
        check("rstmid.value2", int'(value), 2);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            int r, hold;
            logic [6:0] s;
            r = int'($urandom_range(0, 9));
            if (r <= 6)      s = codes[$urandom_range(0, 15)];
            else if (r == 7) s = 7'h7F;
            else if (r == 8) s = 7'($urandom_range(0, 127));
            else             s = codes[($urandom_range(0, 1) != 0) ? (m_value + 1) % 16
                                                                   : (m_value + 15) % 16];
            hold = int'($urandom_range(1, 7));
            for (int k = 0; k < hold; k++)
                step(s, $urandom_range(0, 19) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
